// File: rtl/regfile_param.sv
// Parameterised register file: two combinational read ports, one write port, optional write-to-read bypass.
// A sequential clear walks registers 1..NREGS-1, one per cycle, with busy/done status decoded from state.
module regfile_param #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   A1,
  output logic [XLEN-1:0] RD1,
  input  logic [AW-1:0]   A2,
  output logic [XLEN-1:0] RD2,
  input  logic [AW-1:0]   A3,
  input  logic [XLEN-1:0] WD3,
  input  logic            WE3,
  input  logic            clr_req,
  output logic            clr_busy,
  output logic            clr_done
);

  localparam int NREGS = 2**AW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] regs [NREGS];
  logic            wr_en;
  logic            cnt_last;

  assign cnt_last = (cnt_q == AW'(NREGS - 1));

  // Writes are dropped, not deferred, while the clear walker owns the array.
  assign wr_en = WE3 && (A3 != '0) && (state_q != CLEAR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = AW'(1);
        end
      end
      CLEAR: begin
        // cnt parks at the top index rather than wrapping back to 0.
        if (cnt_last) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    clr_busy = (state_q == CLEAR);
    clr_done = (state_q == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (state_q == CLEAR) begin
      regs[cnt_q] <= '0;
    end else if (wr_en) begin
      regs[A3] <= WD3;
    end
  end

  // Register 0 is hardwired; reset also masks the bypass path so nothing leaks out.
  always_comb begin
    RD1 = regs[A1];
    if ((BYPASS != 0) && wr_en && (A1 == A3)) begin
      RD1 = WD3;
    end
    if (rst || (A1 == '0)) begin
      RD1 = '0;
    end
  end

  always_comb begin
    RD2 = regs[A2];
    if ((BYPASS != 0) && wr_en && (A2 == A3)) begin
      RD2 = WD3;
    end
    if (rst || (A2 == '0)) begin
      RD2 = '0;
    end
  end

endmodule
